// File: rtl/vic_pkg.sv
// Shared VIC constants: default slot count, level encodings and VectCntl field layout.
package vic_pkg;

    localparam int DEF_NUM_VECT = 16;
    localparam int DEF_LVL_W    = 5;

    localparam int LVL_DEF  = DEF_NUM_VECT;
    localparam int LVL_NONE = DEF_NUM_VECT + 1;

    localparam int CNTL_W  = 6;
    localparam int EN_BIT  = 5;
    localparam int SRC_LSB = 0;
    localparam int SRC_W   = 5;

endpackage : vic_pkg

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder: index of the least significant set bit plus a valid flag.
module prio_enc #(
    parameter int W     = 16,
    parameter int IDX_W = 5
) (
    input  logic [W-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [W-1:0] low_s;

    // Isolate the lowest set bit, then OR together the indices of the (single) one-hot bit.
    always_comb begin
        low_s   = vec_i & (~vec_i + {{(W-1){1'b0}}, 1'b1});
        idx_o   = {IDX_W{1'b0}};
        valid_o = |vec_i;
        for (int i = 0; i < W; i++) begin
            idx_o = idx_o | (low_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
    end

endmodule : prio_enc

// File: rtl/int_vect.sv
// Vectored IRQ resolver with an in-service priority stack; only strictly higher
// priority requests than the one in service can raise irq_out.
module int_vect
    import vic_pkg::*;
#(
    parameter int NUM_VECT = DEF_NUM_VECT,
    parameter int LVL_W    = DEF_LVL_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              IRQStatus,
    input  logic [NUM_VECT*6-1:0]    top_reg_VICVectCntl,
    input  logic [NUM_VECT*32-1:0]   top_reg_VICVectAddr,
    input  logic [31:0]              top_reg_VICDefVectAddr,
    input  logic                     vect_ack,
    input  logic                     vect_eoi,
    output logic                     irq_out,
    output logic [31:0]              vect_reg_VICVectAddr,
    output logic [LVL_W-1:0]         vect_level,
    output logic [NUM_VECT:0]        in_service
);

    localparam logic [LVL_W-1:0]  L_DEF  = LVL_W'(NUM_VECT);
    localparam logic [LVL_W-1:0]  L_NONE = LVL_W'(NUM_VECT + 1);
    localparam logic [NUM_VECT:0] ISV_ONE = {{NUM_VECT{1'b0}}, 1'b1};

    logic [NUM_VECT-1:0] hit_s;
    logic [NUM_VECT-1:0] qual_s;
    logic [31:0]         claimed_s;
    logic [SRC_W-1:0]    src_s;
    logic                def_hit_s;
    logic                def_qual_s;

    logic [LVL_W-1:0]    isv_idx_s;
    logic                isv_valid_s;
    logic [LVL_W-1:0]    cur_s;
    logic [LVL_W-1:0]    win_idx_s;
    logic                win_valid_s;
    logic [31:0]         slot_addr_s;

    logic                irq_d,   irq_q;
    logic [31:0]         addr_d,  addr_q;
    logic [LVL_W-1:0]    level_d, level_q;
    logic [NUM_VECT:0]   isv_d,   isv_q;

    // Slot decode: per-slot hits and the set of sources claimed by any enabled slot.
    always_comb begin
        hit_s     = {NUM_VECT{1'b0}};
        claimed_s = 32'h0;
        src_s     = {SRC_W{1'b0}};
        for (int i = 0; i < NUM_VECT; i++) begin
            src_s = top_reg_VICVectCntl[i*CNTL_W+SRC_LSB +: SRC_W];
            if (top_reg_VICVectCntl[i*CNTL_W+EN_BIT]) begin
                hit_s[i]         = IRQStatus[src_s];
                claimed_s[src_s] = 1'b1;
            end else begin
                hit_s[i] = 1'b0;
            end
        end
        def_hit_s = |(IRQStatus & ~claimed_s);
    end

    prio_enc #(.W(NUM_VECT + 1), .IDX_W(LVL_W)) u_isv_enc (
        .vec_i   (isv_q),
        .idx_o   (isv_idx_s),
        .valid_o (isv_valid_s)
    );

    // Qualification against the current in-service level.
    always_comb begin
        cur_s      = isv_valid_s ? isv_idx_s : L_NONE;
        qual_s     = {NUM_VECT{1'b0}};
        for (int i = 0; i < NUM_VECT; i++) begin
            qual_s[i] = hit_s[i] && (LVL_W'(i) < cur_s);
        end
        def_qual_s = def_hit_s && !isv_valid_s;
    end

    prio_enc #(.W(NUM_VECT), .IDX_W(LVL_W)) u_qual_enc (
        .vec_i   (qual_s),
        .idx_o   (win_idx_s),
        .valid_o (win_valid_s)
    );

    // Winning-slot address mux.
    always_comb begin
        slot_addr_s = 32'h0;
        for (int i = 0; i < NUM_VECT; i++) begin
            if (win_idx_s == LVL_W'(i)) begin
                slot_addr_s = top_reg_VICVectAddr[i*32 +: 32];
            end else begin
                slot_addr_s = slot_addr_s;
            end
        end
    end

    // Resolution and in-service update; EOI clears the old lowest bit before the ack bit is ORed in.
    always_comb begin
        irq_d   = 1'b0;
        addr_d  = top_reg_VICDefVectAddr;
        level_d = L_NONE;
        isv_d   = isv_q;

        if (win_valid_s) begin
            irq_d   = 1'b1;
            addr_d  = slot_addr_s;
            level_d = win_idx_s;
        end else if (def_qual_s) begin
            irq_d   = 1'b1;
            addr_d  = top_reg_VICDefVectAddr;
            level_d = L_DEF;
        end else begin
            irq_d   = 1'b0;
            addr_d  = top_reg_VICDefVectAddr;
            level_d = L_NONE;
        end

        if (vect_eoi) begin
            isv_d = isv_d & (isv_d - ISV_ONE);
        end else begin
            isv_d = isv_d;
        end

        if (vect_ack && irq_q) begin
            isv_d = isv_d | (ISV_ONE << level_q);
        end else begin
            isv_d = isv_d;
        end
    end

    // Output and in-service registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q   <= 1'b0;
            addr_q  <= 32'h0;
            level_q <= L_NONE;
            isv_q   <= {(NUM_VECT+1){1'b0}};
        end else begin
            irq_q   <= irq_d;
            addr_q  <= addr_d;
            level_q <= level_d;
            isv_q   <= isv_d;
        end
    end

    assign irq_out              = irq_q;
    assign vect_reg_VICVectAddr = addr_q;
    assign vect_level           = level_q;
    assign in_service           = isv_q;

endmodule : int_vect

// File: tb/tb_int_vect.sv
// Directed self-checking bench for int_vect: vectored/default requests, nesting,
// masking, ack/EOI corner cases and asynchronous reset mid-service.
module tb_int_vect;

    localparam int NV = 16;

    logic              clk;
    logic              rst;
    logic [31:0]       irq_status;
    logic [NV*6-1:0]   vcntl;
    logic [NV*32-1:0]  vaddr;
    logic [31:0]       def_addr;
    logic              ack;
    logic              eoi;
    logic              irq;
    logic [31:0]       vect_addr;
    logic [4:0]        level;
    logic [NV:0]       isv;

    int total;
    int bad;

    int_vect dut (
        .clk                    (clk),
        .rst                    (rst),
        .IRQStatus              (irq_status),
        .top_reg_VICVectCntl    (vcntl),
        .top_reg_VICVectAddr    (vaddr),
        .top_reg_VICDefVectAddr (def_addr),
        .vect_ack               (ack),
        .vect_eoi               (eoi),
        .irq_out                (irq),
        .vect_reg_VICVectAddr   (vect_addr),
        .vect_level             (level),
        .in_service             (isv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        irq_status = 32'h0;
        vcntl      = '0;
        vaddr      = '0;
        def_addr   = 32'hDEF0_0000;
        ack        = 1'b0;
        eoi        = 1'b0;
        // slot 1: src 1, slot 3: src 5, slot 5: src 9, slot 7: src 5 (duplicate of slot 3)
        vcntl[1*6 +: 6]  = 6'b1_00001;
        vcntl[3*6 +: 6]  = 6'b1_00101;
        vcntl[5*6 +: 6]  = 6'b1_01001;
        vcntl[7*6 +: 6]  = 6'b1_00101;
        vaddr[1*32 +: 32] = 32'h1000_0010;
        vaddr[3*32 +: 32] = 32'h1000_0030;
        vaddr[5*32 +: 32] = 32'h1000_0050;
        vaddr[7*32 +: 32] = 32'h1000_0070;

        tick();
        tick();
        check("rst_irq",   {31'h0, irq}, 32'h0);
        check("rst_addr",  vect_addr,    32'h0);
        check("rst_level", {27'h0, level}, 32'd17);
        check("rst_isv",   {15'h0, isv}, 32'h0);
        rst = 1'b0;

        // Vectored request; slot 3 beats slot 7 on the shared source.
        irq_status = 32'h20;
        tick();
        check("vec_irq",   {31'h0, irq}, 32'h1);
        check("vec_addr",  vect_addr,    32'h1000_0030);
        check("vec_level", {27'h0, level}, 32'd3);

        // Withdraw source 5, raise unclaimed source 7.
        irq_status = 32'h80;
        tick();
        check("def_irq",   {31'h0, irq}, 32'h1);
        check("def_addr",  vect_addr,    32'hDEF0_0000);
        check("def_level", {27'h0, level}, 32'd16);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("def_ack_isv", {15'h0, isv}, 32'h10000);
        tick();
        check("def_svc_irq",   {31'h0, irq}, 32'h0);
        check("def_svc_level", {27'h0, level}, 32'd17);

        // Spurious ack leaves the stack alone.
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("spur_ack_isv", {15'h0, isv}, 32'h10000);
        eoi = 1'b1;
        irq_status = 32'h0;
        tick();
        eoi = 1'b0;
        check("def_eoi_isv", {15'h0, isv}, 32'h0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check("empty_eoi_isv", {15'h0, isv}, 32'h0);
        check("idle_irq",      {31'h0, irq}, 32'h0);

        // Nesting: ack slot 3 (held for two cycles; second ack is a no-op).
        irq_status = 32'h20;
        tick();
        check("n_lvl3", {27'h0, level}, 32'd3);
        ack = 1'b1;
        tick();
        check("n_ack3_isv", {15'h0, isv}, 32'h8);
        check("n_ack3_irq_stale", {31'h0, irq}, 32'h1);
        tick();
        ack = 1'b0;
        check("n_b2b_isv", {15'h0, isv}, 32'h8);
        check("n_ack3_irq", {31'h0, irq}, 32'h0);

        irq_status = 32'h22;
        tick();
        check("n_lvl1_irq",  {31'h0, irq}, 32'h1);
        check("n_lvl1",      {27'h0, level}, 32'd1);
        check("n_lvl1_addr", vect_addr,    32'h1000_0010);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("n_ack1_isv", {15'h0, isv}, 32'hA);
        irq_status = 32'h20;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check("n_eoi1_isv", {15'h0, isv}, 32'h8);

        // Masking: slot 5 (src 9) cannot pre-empt slot 3.
        irq_status = 32'h220;
        tick();
        tick();
        check("mask_irq", {31'h0, irq}, 32'h0);
        irq_status = 32'h200;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check("n_eoi3_isv", {15'h0, isv}, 32'h0);
        tick();
        check("mask_rel_irq",  {31'h0, irq}, 32'h1);
        check("mask_rel_lvl",  {27'h0, level}, 32'd5);
        check("mask_rel_addr", vect_addr,    32'h1000_0050);

        // Simultaneous ack (level 1) and EOI with mask 0x8.
        irq_status = 32'h20;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("sim_pre_isv", {15'h0, isv}, 32'h8);
        irq_status = 32'h22;
        tick();
        check("sim_lvl1", {27'h0, level}, 32'd1);
        ack = 1'b1;
        eoi = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b0;
        check("sim_isv", {15'h0, isv}, 32'h2);

        // Rebuild 0xA, then assert reset between clock edges.
        eoi = 1'b1;
        irq_status = 32'h20;
        tick();
        eoi = 1'b0;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        irq_status = 32'h22;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("pre_rst_isv", {15'h0, isv}, 32'hA);
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_irq",   {31'h0, irq}, 32'h0);
        check("mid_rst_addr",  vect_addr,    32'h0);
        check("mid_rst_level", {27'h0, level}, 32'd17);
        check("mid_rst_isv",   {15'h0, isv}, 32'h0);
        tick();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_int_vect
